// File: rtl/ysyx_040750_csr_regfile_if.sv
// CSR register file bus: read port, ALU commit port, trap events and fetch redirect.
interface ysyx_040750_csr_regfile_if #(
    parameter int unsigned XLEN = 64
);
    logic [11:0]     I_csr_raddr;
    logic [XLEN-1:0] O_csr_rdata;
    logic            O_csr_illegal;
    logic            I_csr_wen;
    logic [11:0]     I_csr_waddr;
    logic [XLEN-1:0] I_csr_wdata;
    logic            I_ecall;
    logic            I_mret;
    logic [XLEN-1:0] I_pc;
    logic            O_redirect_valid;
    logic [XLEN-1:0] O_redirect_pc;

    // Pipeline side: issues reads, commits and trap events.
    modport master (
        output I_csr_raddr, I_csr_wen, I_csr_waddr, I_csr_wdata,
        output I_ecall, I_mret, I_pc,
        input  O_csr_rdata, O_csr_illegal, O_redirect_valid, O_redirect_pc
    );

    // Register file side.
    modport slave (
        input  I_csr_raddr, I_csr_wen, I_csr_waddr, I_csr_wdata,
        input  I_ecall, I_mret, I_pc,
        output O_csr_rdata, O_csr_illegal, O_redirect_valid, O_redirect_pc
    );
endinterface

// File: rtl/ysyx_040750_csr_regfile.sv
// Machine-mode CSR register file: storage, write bypass, ecall/mret side effects
// and a registered one-cycle fetch redirect.
module ysyx_040750_csr_regfile #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input logic                      I_sys_clk,
    input logic                      I_rst,
    ysyx_040750_csr_regfile_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    localparam logic [XLEN-1:0] LOW2_CLEAR = ~XLEN'(3);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mcycle_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic [XLEN-1:0] wdata_masked;
    logic [XLEN-1:0] csr_value;
    logic            csr_illegal;

    // mstatus as seen by software: MPP hardwired to M-mode, only MIE/MPIE live.
    function automatic logic [XLEN-1:0] mstatus_word(input logic mpie, input logic mie);
        logic [XLEN-1:0] w;
        w        = '0;
        w[12:11] = 2'b11;
        w[7]     = mpie;
        w[3]     = mie;
        return w;
    endfunction

    function automatic logic is_writable(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MCYCLE: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Apply the per-register write mask so bypass and commit see identical data.
    always_comb begin
        wdata_masked = bus.I_csr_wdata;
        case (bus.I_csr_waddr)
            ADDR_MSTATUS: wdata_masked = mstatus_word(bus.I_csr_wdata[7], bus.I_csr_wdata[3]);
            ADDR_MEPC:    wdata_masked = bus.I_csr_wdata & LOW2_CLEAR;
            default:      ;
        endcase
    end

    // Read mux with same-cycle bypass of a pending commit to the read address.
    always_comb begin
        csr_value   = '0;
        csr_illegal = 1'b0;
        case (bus.I_csr_raddr)
            ADDR_MSTATUS:  csr_value = mstatus_word(mstatus_mpie, mstatus_mie);
            ADDR_MIE:      csr_value = mie_q;
            ADDR_MTVEC:    csr_value = mtvec_q;
            ADDR_MSCRATCH: csr_value = mscratch_q;
            ADDR_MEPC:     csr_value = mepc_q;
            ADDR_MCAUSE:   csr_value = mcause_q;
            ADDR_MIP:      csr_value = '0;
            ADDR_MCYCLE:   csr_value = mcycle_q;
            default:       csr_illegal = 1'b1;
        endcase
        if (bus.I_csr_wen && (bus.I_csr_waddr == bus.I_csr_raddr) && is_writable(bus.I_csr_waddr)) begin
            csr_value = wdata_masked;
        end
    end

    assign bus.O_csr_rdata      = csr_value;
    assign bus.O_csr_illegal    = csr_illegal;
    assign bus.O_redirect_valid = redirect_valid_q;
    assign bus.O_redirect_pc    = redirect_pc_q;

    // CSR state, trap side effects and registered redirect.
    // Trap updates are placed after the CSR write so that, for the registers
    // they touch, their non-blocking assignments override the same-cycle write.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            mstatus_mie      <= 1'b0;
            mstatus_mpie     <= 1'b0;
            mie_q            <= '0;
            mtvec_q          <= '0;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mcycle_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mcycle_q         <= mcycle_q + XLEN'(1);
            redirect_valid_q <= 1'b0;

            if (bus.I_csr_wen) begin
                case (bus.I_csr_waddr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= wdata_masked[3];
                        mstatus_mpie <= wdata_masked[7];
                    end
                    ADDR_MIE:      mie_q      <= wdata_masked;
                    ADDR_MTVEC:    mtvec_q    <= wdata_masked;
                    ADDR_MSCRATCH: mscratch_q <= wdata_masked;
                    ADDR_MEPC:     mepc_q     <= wdata_masked;
                    ADDR_MCAUSE:   mcause_q   <= wdata_masked;
                    ADDR_MCYCLE:   mcycle_q   <= wdata_masked;
                    default:       ;
                endcase
            end

            if (bus.I_ecall) begin
                mepc_q           <= bus.I_pc & LOW2_CLEAR;
                mcause_q         <= XLEN'(ECALL_CAUSE);
                mstatus_mpie     <= mstatus_mie;
                mstatus_mie      <= 1'b0;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mtvec_q & LOW2_CLEAR;
            end else if (bus.I_mret) begin
                mstatus_mie      <= mstatus_mpie;
                mstatus_mpie     <= 1'b1;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mepc_q;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_040750_csr_regfile.sv
// Directed testbench for the CSR register file with a queue-based scoreboard.
module tb_ysyx_040750_csr_regfile;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    ysyx_040750_csr_regfile_if #(.XLEN(64)) bus ();

    ysyx_040750_csr_regfile #(
        .XLEN        (64),
        .ECALL_CAUSE (11)
    ) dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .bus       (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed=%h expected=<none>", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
        push(tag, exp);
        bus.I_csr_raddr = a;
        #1;
        check(bus.O_csr_rdata);
    endtask

    task automatic rd_ill(input logic [11:0] a, input string tag, input logic exp);
        push(tag, 64'(exp));
        bus.I_csr_raddr = a;
        #1;
        check(64'(bus.O_csr_illegal));
    endtask

    initial begin
        rst             = 1'b1;
        bus.I_csr_raddr = '0;
        bus.I_csr_wen   = 1'b0;
        bus.I_csr_waddr = '0;
        bus.I_csr_wdata = '0;
        bus.I_ecall     = 1'b0;
        bus.I_mret      = 1'b0;
        bus.I_pc        = '0;

        // Reset state
        push("rst_valid", 64'd0);
        push("rst_pc", 64'd0);
        tick();
        tick();
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);
        rst = 1'b0;
        tick();
        rd(12'h300, "rst_mstatus", 64'h1800);
        rd(12'h305, "rst_mtvec", 64'h0);
        rd(12'h341, "rst_mepc", 64'h0);
        rd(12'h7C0, "unimpl_rdata", 64'h0);
        rd_ill(12'h7C0, "unimpl_illegal", 1'b1);
        tick();
        rd_ill(12'h300, "mstatus_legal", 1'b0);

        // mtvec write with same-cycle bypass
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h305;
        bus.I_csr_wdata = 64'h8000_0100;
        rd(12'h305, "mtvec_bypass", 64'h8000_0100);
        tick();
        bus.I_csr_wen = 1'b0;
        rd(12'h305, "mtvec_read", 64'h8000_0100);

        // mip is read-only: no bypass, no commit, but legal
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h344;
        bus.I_csr_wdata = '1;
        rd(12'h344, "mip_nobypass", 64'h0);
        tick();
        bus.I_csr_wen = 1'b0;
        rd(12'h344, "mip_read", 64'h0);
        rd_ill(12'h344, "mip_legal", 1'b0);

        // mstatus mask: only MIE/MPIE stored, MPP reads 11
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h300;
        bus.I_csr_wdata = 64'h8;
        rd(12'h300, "mstatus_bypass", 64'h1808);
        tick();
        bus.I_csr_wen = 1'b0;
        rd(12'h300, "mstatus_mie_set", 64'h1808);

        // ecall
        bus.I_ecall = 1'b1;
        bus.I_pc    = 64'h8000_0040;
        push("ecall_valid", 64'd1);
        push("ecall_pc", 64'h8000_0100);
        tick();
        bus.I_ecall = 1'b0;
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);
        rd(12'h341, "ecall_mepc", 64'h8000_0040);
        rd(12'h342, "ecall_mcause", 64'd11);
        rd(12'h300, "ecall_mstatus", 64'h1880);
        push("ecall_pulse_end", 64'd0);
        tick();
        check(64'(bus.O_redirect_valid));

        // mret
        bus.I_mret = 1'b1;
        push("mret_valid", 64'd1);
        push("mret_pc", 64'h8000_0040);
        tick();
        bus.I_mret = 1'b0;
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);
        rd(12'h300, "mret_mstatus", 64'h1888);
        push("mret_pulse_end", 64'd0);
        push("mret_pc_hold", 64'h8000_0040);
        tick();
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);

        // ecall + mret + mepc write together: ecall only
        bus.I_ecall     = 1'b1;
        bus.I_mret      = 1'b1;
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h341;
        bus.I_csr_wdata = 64'h1234;
        bus.I_pc        = 64'h8000_0203;
        push("combo_valid", 64'd1);
        push("combo_pc", 64'h8000_0100);
        tick();
        bus.I_ecall   = 1'b0;
        bus.I_mret    = 1'b0;
        bus.I_csr_wen = 1'b0;
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);
        rd(12'h341, "combo_mepc", 64'h8000_0200);
        rd(12'h342, "combo_mcause", 64'd11);
        rd(12'h300, "combo_mstatus", 64'h1880);
        push("combo_single_pulse", 64'd0);
        tick();
        check(64'(bus.O_redirect_valid));

        // mcycle write precedence and wrap
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'hB00;
        bus.I_csr_wdata = '1;
        tick();
        bus.I_csr_wen = 1'b0;
        rd(12'hB00, "mcycle_written", 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(12'hB00, "mcycle_wrap", 64'h0);
        tick();
        rd(12'hB00, "mcycle_inc", 64'h1);

        // Reset discards a same-cycle trap and write
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h340;
        bus.I_csr_wdata = 64'hDEAD;
        tick();
        bus.I_csr_wen = 1'b0;
        rd(12'h340, "mscratch_write", 64'hDEAD);
        bus.I_ecall     = 1'b1;
        bus.I_pc        = 64'h8000_0080;
        bus.I_csr_wen   = 1'b1;
        bus.I_csr_waddr = 12'h305;
        bus.I_csr_wdata = 64'h44;
        rst             = 1'b1;
        push("rst_drop_valid", 64'd0);
        push("rst_drop_pc", 64'd0);
        tick();
        bus.I_ecall   = 1'b0;
        bus.I_csr_wen = 1'b0;
        check(64'(bus.O_redirect_valid));
        check(bus.O_redirect_pc);
        rd(12'h300, "rst2_mstatus", 64'h1800);
        rd(12'h340, "rst2_mscratch", 64'h0);
        rd(12'h305, "rst2_mtvec", 64'h0);
        rd(12'h341, "rst2_mepc", 64'h0);
        rd(12'h342, "rst2_mcause", 64'h0);
        tick();
        rd(12'hB00, "rst2_mcycle", 64'h0);
        rst = 1'b0;
        push("post_rst_valid", 64'd0);
        tick();
        check(64'(bus.O_redirect_valid));
        rd(12'hB00, "post_rst_mcycle", 64'h1);

        // Every pushed expectation must have been consumed
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_040750_csr_regfile.md
Name: ysyx_040750_csr_regfile

Overview:
Machine-mode CSR register file. It is the storage end of the CSR read-modify-write path. It supplies the current CSR value to the CSR ALU and commits the ALU's result. It also performs the architectural side effects of ecall (trap entry) and mret (trap return), and issues a registered PC redirect to fetch. It sits beside the execute/writeback stages of the pipeline.

Parameters:
XLEN, 64, CSR data width
ECALL_CAUSE, 11, mcause value written on ecall from M-mode

Ports:
I_sys_clk  input  1  clock; all state updates on its rising edge
I_rst  input  1  synchronous, active-high reset
I_csr_raddr  input  12  CSR read address
O_csr_rdata  output  XLEN  read data, combinational, with write bypass
O_csr_illegal  output  1  I_csr_raddr is not an implemented CSR (combinational)
I_csr_wen  input  1  commit I_csr_wdata to I_csr_waddr this edge
I_csr_waddr  input  12  CSR write address
I_csr_wdata  input  XLEN  new CSR value from the CSR ALU
I_ecall  input  1  ecall retiring this cycle
I_mret  input  1  mret retiring this cycle
I_pc  input  XLEN  PC of the retiring ecall
O_redirect_valid  output  1  one-cycle pulse: fetch must jump to O_redirect_pc
O_redirect_pc  output  XLEN  redirect target; holds its value when not valid

Behaviour:
- Implemented CSRs, all reset to 0 except where noted:
  - mstatus 0x300
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mip 0x344: read-only, reads 0; writes ignored
  - mcycle 0xB00
- mstatus write mask:
  - Only MIE[3] and MPIE[7] are stored.
  - MPP[12:11] always reads 2'b11.
  - All other bits read 0.
  - Reset value therefore reads 0x1800.
- mtvec: bits [1:0] stored as written. Redirect target on trap is {mtvec[XLEN-1:2],2'b00} (direct mode only).
- mepc: bits [1:0] forced to 0 on every write.
- Read path:
  - O_csr_rdata is the value of the register selected by I_csr_raddr.
  - Bypass: if I_csr_wen=1 and I_csr_waddr==I_csr_raddr (implemented, writable), O_csr_rdata shows the masked I_csr_wdata in the same cycle.
  - Unimplemented address: O_csr_rdata=0, O_csr_illegal=1.
- Write path: on the edge with I_csr_wen=1, the addressed register takes the masked I_csr_wdata. Writes to unimplemented or read-only addresses are dropped.
- mcycle:
  - Increments by 1 every cycle when not in reset; wraps from all-ones to 0.
  - A CSR write to 0xB00 takes precedence over the increment that cycle: value = wdata, no +1.
- ecall (I_ecall=1) on the edge:
  - mepc<=I_pc & ~3, mcause<=ECALL_CAUSE, MPIE<=MIE, MIE<=0.
  - Next cycle: O_redirect_valid=1, O_redirect_pc=trap base computed from mtvec as it was before the edge.
- mret (I_mret=1) on the edge:
  - MIE<=MPIE, MPIE<=1.
  - Next cycle: O_redirect_valid=1, O_redirect_pc=mepc as it was before the edge.
- Redirect latency is exactly 1 cycle. O_redirect_valid is a single-cycle pulse per event. Back-to-back events produce back-to-back pulses.
- Simultaneous events:
  - I_ecall and I_mret both 1: ecall wins; mret ignored.
  - A CSR write and an ecall/mret in the same cycle: the trap update wins for mstatus/mepc/mcause. A CSR write to any other register still commits.
- Reset:
  - Every register takes its reset value; O_redirect_valid=0, O_redirect_pc=0.
  - Reset asserted mid-operation discards any pending redirect and any same-cycle write or trap.

Test Plan:
- Reset, then read 0x300, 0x305, 0x341 -> 0x1800, 0, 0. Read 0x7C0 -> rdata=0, illegal=1.
- Write mtvec=0x8000_0100; next cycle read -> 0x8000_0100. Same-cycle read of 0x305 during the write -> bypass 0x8000_0100.
- Set MIE via write 0x8 to mstatus, then ecall with I_pc=0x8000_0040 -> mepc=0x8000_0040, mcause=11, mstatus=0x1880. Next cycle redirect_valid=1, redirect_pc=0x8000_0100.
- mret -> mstatus=0x1888. Next cycle redirect pulse to 0x8000_0040, then valid=0 the cycle after.
- ecall and mret asserted together with a mepc write of 0x1234 in the same cycle -> ecall semantics only, mepc=I_pc, one redirect to the trap base.
- Write mcycle=all-ones -> reads 0 one cycle later. Assert reset during a pending redirect -> no pulse, all CSRs at reset values.
